// File: rtl/video_pkg.sv
// Shared constants and helpers for the video/sprite path: PS/2 arrow-key
// scan codes, direction-bit layout, visible-area timing and the decoder state type.
// Pure declarations; no logic, no latency, no flow control.
package video_pkg;

  // Visible area
  localparam int H_PIXELS = 640;
  localparam int V_PIXELS = 480;

  // PS/2 set-2 scan codes used by the arrow decoder
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  // Bit positions inside the 4-bit {up, down, left, right} direction vector.
  // Opposite directions differ only in bit 0 of their index.
  localparam int DIR_U = 3;
  localparam int DIR_D = 2;
  localparam int DIR_L = 1;
  localparam int DIR_R = 0;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_EXT     = 2'd1,
    S_EXT_BRK = 2'd2,
    S_BRK     = 2'd3
  } dec_state_e;

  // Returns {is_arrow, dir_index} for a scan-code byte.
  function automatic logic [2:0] arrow_decode(input logic [7:0] code);
    logic [2:0] res;
    res = 3'b000;
    case (code)
      SC_UP:    res = {1'b1, 2'(DIR_U)};
      SC_DOWN:  res = {1'b1, 2'(DIR_D)};
      SC_LEFT:  res = {1'b1, 2'(DIR_L)};
      SC_RIGHT: res = {1'b1, 2'(DIR_R)};
      default:  res = 3'b000;
    endcase
    return res;
  endfunction

  // Index of the direction on the same axis, pointing the other way.
  function automatic logic [1:0] opposite_dir(input logic [1:0] k);
    return k ^ 2'b01;
  endfunction

endpackage

// File: rtl/ps2_arrow_decoder.sv
// Decodes extended PS/2 arrow make/break sequences into one-cycle strobes.
// Strobes are combinational in the cycle the final byte is valid (0-cycle).
// No backpressure: bytes are consumed whenever byte_vld_i is high.
module ps2_arrow_decoder
  import video_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] byte_i,
  input  logic       byte_vld_i,
  output logic       make_o,
  output logic       brk_o,
  output logic [1:0] key_o
);

  dec_state_e state_q, state_d;
  logic [2:0] arrow;

  assign arrow = arrow_decode(byte_i);

  // State register; reset aborts any partially received sequence.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state and event strobes; only valid bytes advance the FSM.
  always_comb begin
    state_d = state_q;
    make_o  = 1'b0;
    brk_o   = 1'b0;
    key_o   = arrow[1:0];
    if (byte_vld_i) begin
      if (byte_i == SC_EXT) begin
        // An extended prefix always restarts the sequence.
        state_d = S_EXT;
      end else begin
        case (state_q)
          S_IDLE:    state_d = (byte_i == SC_BRK) ? S_BRK : S_IDLE;
          S_EXT: begin
            if (byte_i == SC_BRK) begin
              state_d = S_EXT_BRK;
            end else begin
              make_o  = arrow[2];
              state_d = S_IDLE;
            end
          end
          S_EXT_BRK: begin
            brk_o   = arrow[2];
            state_d = S_IDLE;
          end
          S_BRK:     state_d = S_IDLE;  // non-extended release: drop the code
          default:   state_d = S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/sprite_motion_ctrl.sv
// Arrow-key driven sprite mover: key events steer dir, frame_tick steps the centre, borders bounce.
// dir/key_evt update 1 cycle after the final key byte; position 1 cycle after frame_tick.
// No backpressure: every valid byte and every frame_tick is consumed in its cycle.
module sprite_motion_ctrl #(
  parameter int H_PIXELS = video_pkg::H_PIXELS,
  parameter int V_PIXELS = video_pkg::V_PIXELS,
  parameter int SQ_HALF  = 10,
  parameter int INIT_X   = 320,
  parameter int INIT_Y   = 240,
  parameter int STEP     = 1,
  parameter int STICKY   = 1
) (
  input  logic       vga_clk,
  input  logic       reset,
  input  logic [7:0] ps2_byte,
  input  logic       ps2_byte_valid,
  input  logic       frame_tick,
  output logic [9:0] sq_pos_x,
  output logic [9:0] sq_pos_y,
  output logic [3:0] dir,
  output logic       key_evt
);
  import video_pkg::DIR_U;
  import video_pkg::DIR_D;
  import video_pkg::DIR_L;
  import video_pkg::DIR_R;
  import video_pkg::opposite_dir;

  // Centre limits and step, widened to 11 bits so +/- STEP never wraps.
  localparam logic [10:0] X_MIN  = 11'(SQ_HALF);
  localparam logic [10:0] X_MAX  = 11'(H_PIXELS - 1 - SQ_HALF);
  localparam logic [10:0] Y_MIN  = 11'(SQ_HALF);
  localparam logic [10:0] Y_MAX  = 11'(V_PIXELS - 1 - SQ_HALF);
  localparam logic [10:0] STEP_W = 11'(STEP);

  logic [9:0]  x_q, x_d, y_q, y_d;
  logic [3:0]  dir_q, dir_d;
  logic        key_evt_q, key_evt_d;
  logic        dec_make, dec_brk;
  logic [1:0]  dec_key;
  logic [10:0] x_ext, y_ext, x_inc, x_dec, y_inc, y_dec;

  ps2_arrow_decoder u_dec (
    .clk_i      (vga_clk),
    .rst_i      (reset),
    .byte_i     (ps2_byte),
    .byte_vld_i (ps2_byte_valid),
    .make_o     (dec_make),
    .brk_o      (dec_brk),
    .key_o      (dec_key)
  );

  assign x_ext = {1'b0, x_q};
  assign y_ext = {1'b0, y_q};
  assign x_inc = x_ext + STEP_W;
  assign x_dec = x_ext - STEP_W;
  assign y_inc = y_ext + STEP_W;
  assign y_dec = y_ext - STEP_W;

  // Motion/bounce from the registered dir, then key events overriding dir.
  always_comb begin
    x_d       = x_q;
    y_d       = y_q;
    dir_d     = dir_q;
    key_evt_d = 1'b0;

    if (frame_tick) begin
      // Vertical axis: up wins if both flags are somehow set.
      if (dir_q[DIR_U]) begin
        if (y_ext >= Y_MIN + STEP_W) begin
          y_d = y_dec[9:0];
        end else begin
          y_d          = Y_MIN[9:0];
          dir_d[DIR_U] = 1'b0;
          dir_d[DIR_D] = 1'b1;
        end
      end else if (dir_q[DIR_D]) begin
        if (y_inc <= Y_MAX) begin
          y_d = y_inc[9:0];
        end else begin
          y_d          = Y_MAX[9:0];
          dir_d[DIR_D] = 1'b0;
          dir_d[DIR_U] = 1'b1;
        end
      end

      // Horizontal axis: left wins if both flags are somehow set.
      if (dir_q[DIR_L]) begin
        if (x_ext >= X_MIN + STEP_W) begin
          x_d = x_dec[9:0];
        end else begin
          x_d          = X_MIN[9:0];
          dir_d[DIR_L] = 1'b0;
          dir_d[DIR_R] = 1'b1;
        end
      end else if (dir_q[DIR_R]) begin
        if (x_inc <= X_MAX) begin
          x_d = x_inc[9:0];
        end else begin
          x_d          = X_MAX[9:0];
          dir_d[DIR_R] = 1'b0;
          dir_d[DIR_L] = 1'b1;
        end
      end
    end

    // Key update is applied last so it wins over a same-cycle bounce.
    if (dec_make) begin
      if (dir_q[dec_key]) begin
        // Re-pressing an active direction locks motion to that axis only.
        dir_d          = 4'b0000;
        dir_d[dec_key] = 1'b1;
      end else begin
        dir_d[dec_key]               = 1'b1;
        dir_d[opposite_dir(dec_key)] = 1'b0;
      end
      key_evt_d = 1'b1;
    end else if (dec_brk && (STICKY == 0)) begin
      dir_d[dec_key] = 1'b0;
      key_evt_d      = 1'b1;
    end
  end

  // State registers.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      x_q       <= 10'(INIT_X);
      y_q       <= 10'(INIT_Y);
      dir_q     <= 4'b0000;
      key_evt_q <= 1'b0;
    end else begin
      x_q       <= x_d;
      y_q       <= y_d;
      dir_q     <= dir_d;
      key_evt_q <= key_evt_d;
    end
  end

  assign sq_pos_x = x_q;
  assign sq_pos_y = y_q;
  assign dir      = dir_q;
  assign key_evt  = key_evt_q;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Directed bench: instance A (sticky keys, centred start), instance B (non-sticky, start x=12).
module tb_sprite_motion_ctrl;

  logic       clk = 1'b0;
  logic       rst_a, rst_b;
  logic [7:0] byte_a, byte_b;
  logic       vld_a, vld_b, tick_a, tick_b;
  logic [9:0] x_a, y_a, x_b, y_b;
  logic [3:0] dir_a, dir_b;
  logic       evt_a, evt_b;

  int vec_cnt   = 0;
  int err_cnt   = 0;
  int evt_cnt_a = 0;
  int evt_cnt_b = 0;

  always #20 clk = ~clk;

  sprite_motion_ctrl #(.STICKY(1)) dut_a (
    .vga_clk        (clk),
    .reset          (rst_a),
    .ps2_byte       (byte_a),
    .ps2_byte_valid (vld_a),
    .frame_tick     (tick_a),
    .sq_pos_x       (x_a),
    .sq_pos_y       (y_a),
    .dir            (dir_a),
    .key_evt        (evt_a)
  );

  sprite_motion_ctrl #(.STICKY(0), .INIT_X(12)) dut_b (
    .vga_clk        (clk),
    .reset          (rst_b),
    .ps2_byte       (byte_b),
    .ps2_byte_valid (vld_b),
    .frame_tick     (tick_b),
    .sq_pos_x       (x_b),
    .sq_pos_y       (y_b),
    .dir            (dir_b),
    .key_evt        (evt_b)
  );

  // key_evt pulse counters, sampled mid-cycle
  always @(negedge clk) begin
    if (evt_a) evt_cnt_a++;
    if (evt_b) evt_cnt_b++;
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic send_byte(input bit sel, input logic [7:0] b);
    @(negedge clk);
    if (sel) begin byte_b = b; vld_b = 1'b1; end
    else     begin byte_a = b; vld_a = 1'b1; end
    @(negedge clk);
    vld_a = 1'b0;
    vld_b = 1'b0;
    #1;
  endtask

  task automatic tick(input bit sel);
    @(negedge clk);
    if (sel) tick_b = 1'b1;
    else     tick_a = 1'b1;
    @(negedge clk);
    tick_a = 1'b0;
    tick_b = 1'b0;
    #1;
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    byte_a = 8'h00; byte_b = 8'h00;
    vld_a = 1'b0; vld_b = 1'b0;
    tick_a = 1'b0; tick_b = 1'b0;
    repeat (2) @(negedge clk);
    #1;

    // Reset values
    check_eq("rst_a_x",   int'(x_a),   320);
    check_eq("rst_a_y",   int'(y_a),   240);
    check_eq("rst_a_dir", int'(dir_a), 0);
    check_eq("rst_a_evt", int'(evt_a), 0);
    check_eq("rst_b_x",   int'(x_b),   12);
    check_eq("rst_b_dir", int'(dir_b), 0);
    @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0;

    // Idle frames do not move the sprite
    repeat (3) tick(0);
    check_eq("idle_x",   int'(x_a),   320);
    check_eq("idle_y",   int'(y_a),   240);
    check_eq("idle_dir", int'(dir_a), 0);

    // Up make, then 5 frames upward
    send_byte(0, 8'hE0);
    send_byte(0, 8'h75);
    check_eq("up_dir", int'(dir_a), 4'b1000);
    repeat (5) tick(0);
    check_eq("up_y",    int'(y_a),     235);
    check_eq("up_x",    int'(x_a),     320);
    check_eq("up_evts", evt_cnt_a,     1);

    // Diagonal, axis lock
    send_byte(0, 8'hE0); send_byte(0, 8'h6B);
    check_eq("ul_dir", int'(dir_a), 4'b1010);
    send_byte(0, 8'hE0); send_byte(0, 8'h6B);
    check_eq("lock_l_dir", int'(dir_a), 4'b0010);
    send_byte(0, 8'hE0); send_byte(0, 8'h75);
    check_eq("diag_dir", int'(dir_a), 4'b1010);
    send_byte(0, 8'hE0); send_byte(0, 8'h75);
    check_eq("lock_u_dir", int'(dir_a), 4'b1000);
    check_eq("lock_evts",  evt_cnt_a,   5);

    // Non-extended release is ignored
    send_byte(0, 8'hF0); send_byte(0, 8'h75);
    check_eq("nx_brk_dir",  int'(dir_a), 4'b1000);
    check_eq("nx_brk_evts", evt_cnt_a,   5);

    // Sticky: extended release ignored
    send_byte(0, 8'hE0); send_byte(0, 8'hF0); send_byte(0, 8'h75);
    check_eq("sticky_dir",  int'(dir_a), 4'b1000);
    check_eq("sticky_evts", evt_cnt_a,   5);

    // Repeated E0 resynchronises
    send_byte(0, 8'hE0); send_byte(0, 8'hE0); send_byte(0, 8'h6B);
    check_eq("resync_dir",  int'(dir_a), 4'b1010);
    check_eq("resync_evts", evt_cnt_a,   6);

    // Reset in the middle of a sequence aborts it
    send_byte(0, 8'hE0);
    #5 rst_a = 1'b1;
    #10 rst_a = 1'b0;
    check_eq("midrst_dir", int'(dir_a), 0);
    check_eq("midrst_y",   int'(y_a),   240);
    send_byte(0, 8'h75);
    check_eq("midrst_dir2", int'(dir_a), 0);
    check_eq("midrst_evts", evt_cnt_a,   6);

    // Instance B: left bounce at x = SQ_HALF
    send_byte(1, 8'hE0); send_byte(1, 8'h6B);
    check_eq("b_left_dir", int'(dir_b), 4'b0010);
    tick(1);
    check_eq("b_x_t1", int'(x_b), 11);
    tick(1);
    check_eq("b_x_t2",   int'(x_b),   10);
    check_eq("b_dir_t2", int'(dir_b), 4'b0010);
    tick(1);
    check_eq("b_x_t3",   int'(x_b),   10);
    check_eq("b_dir_t3", int'(dir_b), 4'b0001);
    check_eq("b_y",      int'(y_b),   240);

    // Instance B: non-sticky make then release of right
    send_byte(1, 8'hE0); send_byte(1, 8'h74);
    check_eq("b_mk_r_dir", int'(dir_b), 4'b0001);
    send_byte(1, 8'hE0); send_byte(1, 8'hF0); send_byte(1, 8'h74);
    check_eq("b_brk_r_dir", int'(dir_b), 4'b0000);
    check_eq("b_evts",      evt_cnt_b,   3);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/sprite_motion_ctrl.md
Name: sprite_motion_ctrl

Overview:
- Sequences the movable sprite on the 640x480 VGA display.
- Consumes assembled PS/2 scan-code bytes, decodes arrow-key make/break sequences into a 4-bit direction state, and advances the sprite centre position once per video frame.
- Reverses direction ("bounces") at the visible-area borders.
- Sits between the PS/2 byte receiver and the pixel generator, replacing ad-hoc key and motion logic in the video top level.

Parameters:
- H_PIXELS, 640, visible width in pixels.
- V_PIXELS, 480, visible height in pixels.
- SQ_HALF, 10, sprite half-size; the centre is confined to [SQ_HALF, PIXELS-1-SQ_HALF].
- INIT_X, 320, centre X after reset.
- INIT_Y, 240, centre Y after reset.
- STEP, 1, pixels moved per frame tick (1..SQ_HALF).
- STICKY, 1, 1 = key release ignored; 0 = release clears that direction.

Ports:
- vga_clk  in  1  25 MHz pixel clock; the only clock.
- reset  in  1  asynchronous, active-high reset.
- ps2_byte  in  8  scan-code byte, LSB = first data bit, already bit-order corrected.
- ps2_byte_valid  in  1  single-cycle strobe qualifying ps2_byte.
- frame_tick  in  1  single-cycle strobe, once per frame, asserted during vertical blanking.
- sq_pos_x  out  10  sprite centre X.
- sq_pos_y  out  10  sprite centre Y.
- dir  out  4  {up, down, left, right} motion flags.
- key_evt  out  1  one-cycle pulse on any accepted arrow make/break.

Behaviour:
- Reset (async assert, sync release):
  - sq_pos_x = INIT_X, sq_pos_y = INIT_Y.
  - dir = 4'b0000, key_evt = 0.
  - Decoder state = S_IDLE.
- Decoder FSM advances only on cycles where ps2_byte_valid=1.
  - S_IDLE: 0xE0 -> S_EXT; 0xF0 -> S_BRK; any other byte -> S_IDLE.
  - S_EXT: 0xF0 -> S_EXT_BRK. 0x75/0x72/0x6B/0x74 -> make event for up/down/left/right, then S_IDLE. Any other byte -> S_IDLE.
  - S_EXT_BRK: arrow code -> break event, then S_IDLE. Any other byte -> S_IDLE.
  - S_BRK: next byte discarded -> S_IDLE (non-extended release).
  - 0xE0 received in any state -> S_EXT (resynchronisation).
- Make event for direction D:
  - If D is already set: dir becomes D only; all other bits clear (axis lock).
  - Otherwise: set D and clear its opposite; the perpendicular bit is kept, giving diagonal motion.
  - key_evt pulses on the cycle after the final byte.
- Break event:
  - STICKY=1: no dir change, no key_evt.
  - STICKY=0: clear D, pulse key_evt.
- Motion on frame_tick uses dir as registered before the current cycle.
  - up: if sq_pos_y >= SQ_HALF+STEP then sq_pos_y -= STEP. Otherwise sq_pos_y = SQ_HALF, up cleared, down set.
  - down: if sq_pos_y + STEP <= V_PIXELS-1-SQ_HALF then sq_pos_y += STEP. Otherwise clamp to V_PIXELS-1-SQ_HALF, down cleared, up set.
  - left and right: same rules on X with H_PIXELS.
  - Position arithmetic is done in 11 bits, so no 10-bit wrap can occur.
- Simultaneous frame_tick and a decoded make event in the same cycle:
  - The position step uses the old dir.
  - The bounce flip and the key update both write dir; the key update wins.
- Latency:
  - dir and key_evt update 1 cycle after the final valid byte.
  - Position updates 1 cycle after frame_tick.
- Both up and down set at once is unreachable; if forced, up takes priority and down is ignored. The same applies to left over right.
- Reset asserted mid-sequence (for example in S_EXT) aborts the sequence; no event is produced.

Decomposition:
- Shared package `video_pkg`:
  - Scan-code constants SC_EXT=0xE0, SC_BRK=0xF0, SC_UP=0x75, SC_DOWN=0x72, SC_LEFT=0x6B, SC_RIGHT=0x74.
  - Direction bit indices DIR_U=3, DIR_D=2, DIR_L=1, DIR_R=0.
  - Timing constants H_PIXELS and V_PIXELS.
- One sub-module, `ps2_arrow_decoder`:
  - Contains the 4-state FSM.
  - Outputs make/break strobes plus a 2-bit key index.
- Motion and bounce logic stays in the parent.

Test Plan:
- Reset, then 3 frame_ticks with no bytes -> pos stays (320,240), dir=0000.
- Bytes E0,75, then 5 frame_ticks -> dir=1000, sq_pos_y=235, key_evt exactly 1 pulse.
- dir=0010 (left), then E0,75 -> dir=1010; E0,75 again -> dir=1000 (axis lock).
- Left held from x=12 with STEP=1, then 3 ticks -> x=11, 10, then bounce: x=10, dir=0001.
- STICKY=0: E0,74 then E0,F0,74 -> dir 0001 then 0000, 2 key_evt pulses. STICKY=1: same bytes -> dir stays 0001.
- F0,75 (non-extended release) -> no dir change. E0,E0,6B -> left make accepted. Reset asserted between E0 and 75, then 75 -> no event.
